// File: rtl/segment_stream_pkg.sv
// segment_stream_pkg: register map, bit positions and FSM encodings
// shared by the segment_stream receive path.
package segment_stream_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_PKT    = 2'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 2;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {W_IDLE, W_BRESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

    // Fill count squeezed into the 8-bit STATUS field.
    function automatic logic [7:0] sat8(input logic [8:0] c);
        return c[8] ? 8'hFF : c[7:0];
    endfunction

endpackage

// File: rtl/segment_stream_fifo.sv
// segment_stream_fifo: synchronous FIFO with flush; the head word,
// count and flags are all registered so readers see plain flops.
module segment_stream_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [W-1:0]  head_q, head_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          push_ok, pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    // Next pointers, count and the word that will sit at the head.
    always_comb begin
        wr_d = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d = pop_ok ? rd_q + 1'b1 : rd_q;
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
        if (cnt_d == '0) begin
            head_d = '0;
        end else if (push_ok && wr_q == rd_d) begin
            head_d = din_i;
        end else begin
            head_d = mem_q[rd_d];
        end
        full_d  = (cnt_d == (AW+1)'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    // Storage array; contents beyond the count are don't-care.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= din_i;
        end
    end

    // Pointer, count, flag and head registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign dout_o  = head_q;
    assign count_o = cnt_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/segment_stream_sink.sv
// segment_stream_sink: AXI-Stream words queued in a FIFO and drained
// by the PS through an AXI4-Lite window; IRQ flags pending data.
module segment_stream_sink
    import segment_stream_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_FIFO_DEPTH         = 8,
    parameter int C_S_AXI_ADDR_WIDTH   = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                            S_AXIS_TVALID,
    input  logic                            S_AXIS_TLAST,
    output logic                            S_AXIS_TREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [31:0]                     S_AXI_WDATA,
    input  logic [3:0]                      S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [31:0]                     S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            IRQ
);

    localparam int CW = $clog2(C_FIFO_DEPTH) + 1;

    wr_state_e   wst_q;
    rd_state_e   rst_q;
    logic        awready_q, bvalid_q, arready_q, rvalid_q;
    logic [31:0] rdata_q, rdata_d;
    logic        en_q, irq_en_q, flush_q;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    logic          wr_hs, rd_hs, push, pop;
    logic [1:0]    wr_idx, rd_idx;
    logic [32:0]   fifo_dout;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full, fifo_empty;
    logic          unused_ok;

    assign wr_idx = S_AXI_AWADDR[3:2];
    assign rd_idx = S_AXI_ARADDR[3:2];
    assign wr_hs  = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_hs  = arready_q && S_AXI_ARVALID;

    assign S_AXIS_TREADY = en_q && !fifo_full;
    assign push = S_AXIS_TVALID && S_AXIS_TREADY;
    assign pop  = rd_hs && (rd_idx == REG_DATA);

    segment_stream_fifo #(
        .W     (33),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush_q),
        .din_i   ({S_AXIS_TLAST, S_AXIS_TDATA}),
        .dout_o  (fifo_dout),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Register read mux, sampled on the AR handshake.
    always_comb begin
        rdata_d = '0;
        unique case (rd_idx)
            REG_CTRL: begin
                rdata_d[CTRL_EN]     = en_q;
                rdata_d[CTRL_IRQ_EN] = irq_en_q;
            end
            REG_STATUS: begin
                rdata_d[STAT_EMPTY] = fifo_empty;
                rdata_d[STAT_FULL]  = fifo_full;
                rdata_d[15:8]       = sat8(9'(fifo_cnt));
            end
            REG_DATA: rdata_d = fifo_empty ? '0 : fifo_dout[31:0];
            REG_PKT: begin
                rdata_d[0]    = !fifo_empty && fifo_dout[32];
                rdata_d[23:8] = pkt_cnt_q;
            end
        endcase
    end

    // Packet counter: a register write clears it, TLAST beats bump it.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (push && S_AXIS_TLAST) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
        if (wr_hs && wr_idx == REG_PKT) begin
            pkt_cnt_d = '0;
        end
    end

    // CTRL fields, one-shot flush and packet counter.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            flush_q   <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            flush_q   <= 1'b0;
            pkt_cnt_q <= pkt_cnt_d;
            if (wr_hs && wr_idx == REG_CTRL) begin
                en_q     <= S_AXI_WDATA[CTRL_EN];
                irq_en_q <= S_AXI_WDATA[CTRL_IRQ_EN];
                flush_q  <= S_AXI_WDATA[CTRL_FLUSH];
            end
        end
    end

    // Write channel: accept AW+W together, then hold B until taken.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wst_q     <= W_IDLE;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            unique case (wst_q)
                W_IDLE: begin
                    if (wr_hs) begin
                        awready_q <= 1'b0;
                        bvalid_q  <= 1'b1;
                        wst_q     <= W_BRESP;
                    end else begin
                        awready_q <= S_AXI_AWVALID && S_AXI_WVALID
                                     && !awready_q;
                    end
                end
                W_BRESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q <= 1'b0;
                        wst_q    <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // Read channel: capture data on AR, hold R until taken; a waiting
    // AR is re-armed as R completes to sustain one read per 2 cycles.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rst_q     <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            unique case (rst_q)
                R_IDLE: begin
                    if (rd_hs) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rdata_d;
                        rst_q     <= R_DATA;
                    end else begin
                        arready_q <= S_AXI_ARVALID && !arready_q;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= S_AXI_ARVALID;
                        rst_q     <= R_IDLE;
                    end
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign IRQ           = irq_en_q && !fifo_empty;

    assign unused_ok = ^{S_AXI_WSTRB, S_AXI_WDATA[31:3],
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_segment_stream_sink.sv
// tb_segment_stream_sink: directed bench for the stream sink,
// covering reset, fill/drain, empty read, push+pop, flush, reset.
module tb_segment_stream_sink;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] S_AXIS_TDATA;
    logic        S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TREADY;
    logic [3:0]  S_AXI_AWADDR, S_AXI_ARADDR;
    logic        S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID, S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY;
    logic        S_AXI_ARVALID, S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic        IRQ;

    int vectors = 0;
    int miscompares = 0;

    always #5 ACLK = ~ACLK;

    segment_stream_sink #(
        .C_S_AXIS_TDATA_WIDTH (32),
        .C_FIFO_DEPTH         (8),
        .C_S_AXI_ADDR_WIDTH   (4)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .IRQ           (IRQ)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expire(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        S_AXI_AWADDR  = a;
        S_AXI_WDATA   = d;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b1;
        while (!S_AXI_AWREADY && n < 20) begin
            tick();
            n++;
        end
        if (!S_AXI_AWREADY) expire("aw_handshake");
        check("wready_with_awready", S_AXI_WREADY, 1);
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("bvalid_latency", S_AXI_BVALID, 1);
        check("bresp", S_AXI_BRESP, 0);
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, input bit do_push,
                            input logic [31:0] pdata,
                            output logic [31:0] d);
        int n = 0;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b1;
        while (!S_AXI_ARREADY && n < 20) begin
            tick();
            n++;
        end
        if (!S_AXI_ARREADY) expire("ar_handshake");
        if (do_push) begin
            S_AXIS_TDATA  = pdata;
            S_AXIS_TLAST  = 1'b0;
            S_AXIS_TVALID = 1'b1;
        end
        tick();
        S_AXI_ARVALID = 1'b0;
        S_AXIS_TVALID = 1'b0;
        check("rvalid_latency", S_AXI_RVALID, 1);
        check("rresp", S_AXI_RRESP, 0);
        d = S_AXI_RDATA;
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        int n = 0;
        S_AXIS_TDATA  = d;
        S_AXIS_TLAST  = last;
        S_AXIS_TVALID = 1'b1;
        while (!S_AXIS_TREADY && n < 20) begin
            tick();
            n++;
        end
        if (!S_AXIS_TREADY) expire("tready_wait");
        tick();
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        axi_read(a, 1'b0, '0, d);
        check(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        int n;
        ARESET        = 1'b1;
        S_AXIS_TDATA  = '0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        S_AXI_AWADDR  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
        repeat (5) tick();

        check("rst_tready", S_AXIS_TREADY, 0);
        check("rst_irq", IRQ, 0);
        check("rst_awready", S_AXI_AWREADY, 0);
        check("rst_wready", S_AXI_WREADY, 0);
        check("rst_bvalid", S_AXI_BVALID, 0);
        check("rst_arready", S_AXI_ARREADY, 0);
        check("rst_rvalid", S_AXI_RVALID, 0);
        check("rst_rdata", S_AXI_RDATA, 0);
        ARESET = 1'b0;
        tick();
        rd_chk("rst_status", 4'h4, 32'h0000_0001);
        rd_chk("rst_pkt", 4'hC, 32'h0000_0000);

        axi_write(4'h0, 32'h3);
        for (int i = 1; i <= 8; i++) beat(i, i == 8);
        check("full_tready", S_AXIS_TREADY, 0);
        check("full_irq", IRQ, 1);
        rd_chk("full_status", 4'h4, 32'h0000_0802);
        rd_chk("full_pkt", 4'hC, 32'h0000_0100);
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) rd_chk("last_head_pkt", 4'hC, 32'h0000_0101);
            rd_chk("drain_data", 4'h8, i);
        end
        rd_chk("drained_status", 4'h4, 32'h0000_0001);
        check("drained_irq", IRQ, 0);

        rd_chk("empty_data", 4'h8, 32'h0);
        rd_chk("empty_status", 4'h4, 32'h0000_0001);

        for (int i = 0; i < 3; i++) beat(32'h11 + i, 1'b0);
        rd_chk("pp_pre_status", 4'h4, 32'h0000_0300);
        for (int k = 0; k < 3; k++) begin
            axi_read(4'h8, 1'b1, 32'h14 + k, d);
            check("pp_data", d, 32'h11 + k);
            rd_chk("pp_status", 4'h4, 32'h0000_0300);
        end
        for (int k = 0; k < 3; k++) rd_chk("pp_tail", 4'h8, 32'h14 + k);
        rd_chk("pp_status_end", 4'h4, 32'h0000_0001);

        for (int i = 0; i < 5; i++) beat(32'h21 + i, 1'b0);
        rd_chk("fl_pre_status", 4'h4, 32'h0000_0500);
        axi_write(4'h0, 32'h7);
        rd_chk("fl_status", 4'h4, 32'h0000_0001);
        rd_chk("fl_ctrl", 4'h0, 32'h0000_0003);
        check("fl_irq", IRQ, 0);
        rd_chk("pkt_before_clr", 4'hC, 32'h0000_0100);
        axi_write(4'hC, 32'h0);
        rd_chk("pkt_after_clr", 4'hC, 32'h0000_0000);
        axi_write(4'h0, 32'h0);
        S_AXIS_TDATA  = 32'hDEAD;
        S_AXIS_TVALID = 1'b1;
        tick();
        check("dis_tready", S_AXIS_TREADY, 0);
        tick();
        check("dis_tready2", S_AXIS_TREADY, 0);
        S_AXIS_TVALID = 1'b0;
        rd_chk("dis_status", 4'h4, 32'h0000_0001);

        axi_write(4'h0, 32'h1);
        beat(32'h30, 1'b1);
        rd_chk("mp_pkt", 4'hC, 32'h0000_0101);
        for (int i = 1; i <= 3; i++) beat(32'h30 + i, 1'b0);
        rd_chk("mp_status", 4'h4, 32'h0000_0400);
        S_AXI_ARADDR  = 4'h4;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b0;
        n = 0;
        while (!S_AXI_ARREADY && n < 20) begin
            tick();
            n++;
        end
        if (!S_AXI_ARREADY) expire("mp_ar_handshake");
        tick();
        S_AXI_ARVALID = 1'b0;
        tick();
        check("mp_rvalid_held", S_AXI_RVALID, 1);
        check("mp_rdata_held", S_AXI_RDATA, 32'h0000_0400);
        ARESET        = 1'b1;
        S_AXIS_TDATA  = 32'h34;
        S_AXIS_TVALID = 1'b1;
        tick();
        check("mp_rvalid", S_AXI_RVALID, 0);
        check("mp_rdata", S_AXI_RDATA, 0);
        check("mp_tready", S_AXIS_TREADY, 0);
        check("mp_irq", IRQ, 0);
        ARESET        = 1'b0;
        S_AXIS_TVALID = 1'b0;
        tick();
        rd_chk("mp_status_after", 4'h4, 32'h0000_0001);
        rd_chk("mp_pkt_after", 4'hC, 32'h0000_0000);
        rd_chk("mp_ctrl_after", 4'h0, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
